// File: rtl/ucore_port_responder.sv
// ucore_port_responder
//
// Purpose:
//   Responder end of a ucore request/response port pair. It accepts one
//   request at a time from a ucore FSM initiator. After WAIT_CYC wait states
//   it serves a read or write from a local register array. It then holds a
//   response until the initiator takes it.
//
// Parameters:
//   ADDR_W    request address width
//   DATA_W    data width
//   DEPTH     implemented words (1..2**ADDR_W); addresses >= DEPTH are unmapped
//   WAIT_CYC  wait states between accept and response (0..255)
//
// Ports:
//   clk        in   rising-edge clock
//   areset     in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE and out of reset)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  response present
//   rsp_ready  in   initiator takes the response
//   rsp_rdata  out  read data, or echo of the write data
//   rsp_err    out  unmapped-access flag
//   busy       out  request outstanding
//
// Configuration:
//   UCORE_RESP_ERR_EN  when defined, rsp_err flags responses to unmapped
//                      addresses. Otherwise rsp_err is tied to 0.

module ucore_port_responder #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0]      WAIT_L  = 8'(WAIT_CYC);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       run_q;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_mapped;

  // run_q is low while areset is asserted. It sets on the first edge after
  // release, so req_ready stays low through reset and rises one cycle later.
  assign req_ready = (state == S_IDLE) && run_q;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // With WAIT_CYC=0 the accept edge is also the commit edge. At that point
  // the captured fields are not loaded yet, so the live request is used.
  assign op_we     = (state == S_IDLE) ? req_we    : cap_we;
  assign op_addr   = (state == S_IDLE) ? req_addr  : cap_addr;
  assign op_wdata  = (state == S_IDLE) ? req_wdata : cap_wdata;
  assign op_mapped = ({1'b0, op_addr} < DEPTH_L);

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_next   = WAIT_L;
          state_next = (WAIT_L != 8'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        // cnt is loaded non-zero on entry, so it never wraps here.
        cnt_next = cnt - 8'd1;
        if (cnt == 8'd1) state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      run_q     <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      run_q <= 1'b1;
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      // Response data is registered on entry to RESP and held from then on.
      if (enter_resp) begin
        if (op_we)          rsp_rdata <= op_wdata;
        else if (op_mapped) rsp_rdata <= mem[op_addr];
        else                rsp_rdata <= '0;
      end
    end
  end

  // NOTE: the array must read as zero after reset, so it is cleared word by
  // word. That keeps it out of RAM macros, which is acceptable at this size.
  // Writes to unmapped addresses are dropped.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && op_we && op_mapped) begin
      mem[op_addr] <= op_wdata;
    end
  end

`ifdef UCORE_RESP_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset)          err_q <= 1'b0;
    else if (enter_resp) err_q <= !op_mapped;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ucore_port_responder.sv
// tb_ucore_port_responder
//
// Directed bench for ucore_port_responder. Instance dut_a uses WAIT_CYC=2 and
// DEPTH=12. Instance dut_b uses WAIT_CYC=0 and DEPTH=16. Both instances share
// clk and areset. Inputs are driven and outputs sampled on the falling edge.
// Expected values are written out by hand.

module tb_ucore_port_responder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

`ifdef UCORE_RESP_ERR_EN
  localparam logic ERR_UNMAPPED = 1'b1;
`else
  localparam logic ERR_UNMAPPED = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset;

  logic              req_valid_a, req_ready_a, req_we_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [DATA_W-1:0] req_wdata_a;
  logic              rsp_valid_a, rsp_ready_a, rsp_err_a, busy_a;
  logic [DATA_W-1:0] rsp_rdata_a;

  logic              req_valid_b, req_ready_b, req_we_b;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_wdata_b;
  logic              rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
  logic [DATA_W-1:0] rsp_rdata_b;

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  ucore_port_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(12), .WAIT_CYC(2)) dut_a (
    .clk(clk), .areset(areset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .busy(busy_a)
  );

  ucore_port_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(16), .WAIT_CYC(0)) dut_b (
    .clk(clk), .areset(areset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on dut_a, issued at a falling edge. The response must
  // appear WAIT_CYC+1 = 3 falling edges later. hold is the number of cycles
  // the response is back-pressured before rsp_ready is raised.
  task automatic txn_a(input string tag, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int hold);
    int n;
    req_valid_a = 1'b1;
    req_we_a    = we;
    req_addr_a  = addr;
    req_wdata_a = wdata;
    rsp_ready_a = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      // Fields change after the accept cycle and must be ignored.
      req_valid_a = 1'b0;
      req_we_a    = ~we;
      req_addr_a  = 4'h2;
      req_wdata_a = 32'hBAD0_BAD0;
    end while (!rsp_valid_a && n < 20);
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " rdata"},   rsp_rdata_a, exp_data);
    check({tag, " err"},     32'(rsp_err_a), 32'(exp_err));
    check({tag, " busy"},    32'(busy_a), 32'd1);
    check({tag, " rdy low"}, 32'(req_ready_a), 32'd0);
    for (int i = 0; i < hold; i++) begin
      // A pending request during back-pressure must not be accepted.
      req_valid_a = 1'b1;
      @(negedge clk);
      check({tag, " hold valid"}, 32'(rsp_valid_a), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata_a, exp_data);
      check({tag, " hold rdy"},   32'(req_ready_a), 32'd0);
    end
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b1;
    @(negedge clk);
    check({tag, " rsp drop"}, 32'(rsp_valid_a), 32'd0);
    check({tag, " idle rdy"}, 32'(req_ready_a), 32'd1);
    check({tag, " idle busy"}, 32'(busy_a), 32'd0);
    // rsp_ready stays high into the idle period, where it must do nothing.
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } op_t;

  op_t ops_b [4];

  initial begin
    areset      = 1'b1;
    req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; rsp_ready_a = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b0;

    // Reset state and release.
    repeat (2) @(negedge clk);
    check("rst rdy", 32'(req_ready_a), 32'd0);
    check("rst valid", 32'(rsp_valid_a), 32'd0);
    areset = 1'b0;
    #1;
    check("rel rdy same cycle", 32'(req_ready_a), 32'd0);
    @(negedge clk);
    check("rel rdy", 32'(req_ready_a), 32'd1);
    check("rel busy", 32'(busy_a), 32'd0);
    check("rel rdata", rsp_rdata_a, 32'd0);
    check("rel err", 32'(rsp_err_a), 32'd0);

    // Idle with rsp_ready high and no request: nothing happens.
    rsp_ready_a = 1'b1;
    repeat (2) @(negedge clk);
    check("idle valid", 32'(rsp_valid_a), 32'd0);
    check("idle busy", 32'(busy_a), 32'd0);

    // Write, read back, then a back-pressured read.
    txn_a("wr3", 1'b1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    txn_a("rd3", 1'b0, 4'd3, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    txn_a("rd3 bp", 1'b0, 4'd3, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // Mapped boundary (11) and unmapped addresses (12, 13) with DEPTH=12.
    txn_a("wr11", 1'b1, 4'd11, 32'hCAFE0011, 32'hCAFE0011, 1'b0, 0);
    txn_a("rd11", 1'b0, 4'd11, 32'h0, 32'hCAFE0011, 1'b0, 0);
    txn_a("wr13", 1'b1, 4'd13, 32'h00000055, 32'h00000055, ERR_UNMAPPED, 0);
    txn_a("rd13", 1'b0, 4'd13, 32'h0, 32'h0, ERR_UNMAPPED, 0);
    txn_a("rd12", 1'b0, 4'd12, 32'h0, 32'h0, ERR_UNMAPPED, 1);
    txn_a("rd3 again", 1'b0, 4'd3, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // WAIT_CYC=0 instance: two writes, then back-to-back reads. Each
    // response takes exactly two cycles.
    ops_b[0] = '{we: 1'b1, addr: 4'd0, wdata: 32'h11111111, exp: 32'h11111111};
    ops_b[1] = '{we: 1'b1, addr: 4'd1, wdata: 32'h22222222, exp: 32'h22222222};
    ops_b[2] = '{we: 1'b0, addr: 4'd0, wdata: 32'h0,        exp: 32'h11111111};
    ops_b[3] = '{we: 1'b0, addr: 4'd1, wdata: 32'h0,        exp: 32'h22222222};
    rsp_ready_b = 1'b1;
    req_valid_b = 1'b1;
    {req_we_b, req_addr_b, req_wdata_b} = {ops_b[0].we, ops_b[0].addr, ops_b[0].wdata};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b%0d valid", i), 32'(rsp_valid_b), 32'd1);
      check($sformatf("b%0d rdata", i), rsp_rdata_b, ops_b[i].exp);
      check($sformatf("b%0d rdy", i), 32'(req_ready_b), 32'd0);
      @(negedge clk);
      check($sformatf("b%0d drop", i), 32'(rsp_valid_b), 32'd0);
      check($sformatf("b%0d idle rdy", i), 32'(req_ready_b), 32'd1);
      if (i < 3) {req_we_b, req_addr_b, req_wdata_b} = {ops_b[i+1].we, ops_b[i+1].addr, ops_b[i+1].wdata};
      else req_valid_b = 1'b0;
    end

    // Reset during WAIT of a write to addr 2: outputs clear immediately and
    // no response is issued.
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 4'd2; req_wdata_a = 32'h12345678;
    rsp_ready_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0;
    check("mid busy", 32'(busy_a), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    check("mid rst valid", 32'(rsp_valid_a), 32'd0);
    check("mid rst busy", 32'(busy_a), 32'd0);
    check("mid rst rdy", 32'(req_ready_a), 32'd0);
    check("mid rst rdata", rsp_rdata_a, 32'd0);
    check("mid rst b rdata", rsp_rdata_b, 32'd0);
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post rst no rsp", 32'(rsp_valid_a), 32'd0);
    end
    txn_a("rd2", 1'b0, 4'd2, 32'h0, 32'h0, 1'b0, 0);
    txn_a("rd3 cleared", 1'b0, 4'd3, 32'h0, 32'h0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
